// File: rtl/shift_rnd_pipe.sv
// shift_rnd_pipe
//   Multi-lane arithmetic right shift with selectable rounding and saturation,
//   implemented as a two-stage valid/ready pipeline.
//
//   Stage 1 shifts every lane by T = i_shift + (width_i - width_o) and registers
//   the kept bits, round bit R, sticky bit S, sign and rounding mode.
//   Stage 2 applies the rounding increment, saturates to width_o and registers
//   o_rnd / o_ofl.
//
//   Optional feature: define SHIFT_RND_OFL_CNT_EN to build the 16-bit saturating
//   overflow-beat counter on o_ofl_cnt. Without it o_ofl_cnt is tied to 0 and
//   i_cnt_clr is ignored.
//
//   Ports
//     i_clk, i_rst_n       clock (rising edge), asynchronous active-low reset
//     i_num                n_lanes signed inputs, lane k at [k*width_i +: width_i]
//     i_shift              unsigned shift shared by all lanes
//     i_mode               00 RNE, 01 RTZ, 10 RNA, 11 RDN (floor)
//     i_valid / o_ready    input handshake
//     o_rnd, o_ofl         rounded/saturated lanes and per-lane clamp flags
//     o_valid / i_ready    output handshake
//     i_cnt_clr            synchronous clear of o_ofl_cnt (wins over increment)
//     o_ofl_cnt            count of output transfers with any o_ofl bit set
//
//   Handshake: a beat moves on a rising edge when valid and ready are both high
//   on that edge. The producer holds valid and data stable until the transfer;
//   ready may depend combinationally on the downstream ready (o_ready follows
//   i_ready when both stages are full), valid never depends on ready.
module shift_rnd_pipe #(
  parameter int n_lanes     = 4,
  parameter int width_i     = 9,
  parameter int width_o     = 8,
  parameter int width_shift = $clog2(width_i + 2)
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [n_lanes*width_i-1:0]   i_num,
  input  logic [width_shift-1:0]       i_shift,
  input  logic [1:0]                   i_mode,
  input  logic                         i_valid,
  output logic                         o_ready,
  output logic [n_lanes*width_o-1:0]   o_rnd,
  output logic [n_lanes-1:0]           o_ofl,
  output logic                         o_valid,
  input  logic                         i_ready,
  input  logic                         i_cnt_clr,
  output logic [15:0]                  o_ofl_cnt
);

  localparam int W1 = width_o + 1;
  // Extended width covers the largest possible T plus the kept bits, so the
  // shift always sees the sign-extended input and never runs off the end.
  localparam int EW = (1 << width_shift) + width_i + width_o + 2;
  localparam int TW = 32;

  // ---------------- stage 1: shift, round and sticky bits ----------------
  logic [TW-1:0]                 w_t;
  logic [EW-1:0]                 w_ext;
  logic [EW:0]                   w_mask;
  logic [n_lanes-1:0][width_o:0] w_shf;
  logic [n_lanes-1:0]            w_r;
  logic [n_lanes-1:0]            w_s;
  logic [n_lanes-1:0]            w_sgn;

  // Full-width total shift so that i_shift + (width_i - width_o) never wraps.
  assign w_t = TW'(i_shift) + TW'(width_i - width_o);

  always_comb begin
    w_ext  = '0;
    w_mask = '0;
    w_shf  = '0;
    w_r    = '0;
    w_s    = '0;
    w_sgn  = '0;
    for (int k = 0; k < n_lanes; k++) begin
      w_ext    = {{(EW-width_i){i_num[k*width_i+width_i-1]}}, i_num[k*width_i +: width_i]};
      w_shf[k] = W1'(w_ext >> w_t);
      // Appending a zero below bit 0 makes T=0 yield R=0 naturally.
      w_r[k]   = 1'(({w_ext, 1'b0}) >> w_t);
      // Ones in bits 0..T-2 (empty for T<=1).
      w_mask   = ~({(EW+1){1'b1}} << w_t) >> 1;
      w_s[k]   = |({1'b0, w_ext} & w_mask);
      w_sgn[k] = w_ext[EW-1];
    end
  end

  logic                          r_s1_valid;
  logic [n_lanes-1:0][width_o:0] r_s1_shf;
  logic [n_lanes-1:0]            r_s1_r;
  logic [n_lanes-1:0]            r_s1_s;
  logic [n_lanes-1:0]            r_s1_sgn;
  logic [1:0]                    r_s1_mode;

  logic w_adv;
  logic r_s2_valid;

  // Stage 2 advances whenever its slot is empty or being drained.
  assign w_adv   = !r_s2_valid | i_ready;
  assign o_ready = !r_s1_valid | w_adv;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_shf   <= '0;
      r_s1_r     <= '0;
      r_s1_s     <= '0;
      r_s1_sgn   <= '0;
      r_s1_mode  <= 2'b00;
    end else if (o_ready) begin
      r_s1_valid <= i_valid;
      if (i_valid) begin
        r_s1_shf  <= w_shf;
        r_s1_r    <= w_r;
        r_s1_s    <= w_s;
        r_s1_sgn  <= w_sgn;
        r_s1_mode <= i_mode;
      end
    end
  end

  // ---------------- stage 2: increment and saturate ----------------
  logic [n_lanes-1:0]            w_inc;
  logic [n_lanes-1:0][width_o:0] w_sum;
  logic [n_lanes-1:0]            w_ofl;
  logic [n_lanes*width_o-1:0]    w_rnd;

  always_comb begin
    w_inc = '0;
    w_sum = '0;
    w_ofl = '0;
    w_rnd = '0;
    for (int k = 0; k < n_lanes; k++) begin
      unique case (r_s1_mode)
        2'b00:   w_inc[k] = r_s1_r[k] & (r_s1_shf[k][0] | r_s1_s[k]);
        2'b01:   w_inc[k] = r_s1_sgn[k] & (r_s1_r[k] | r_s1_s[k]);
        2'b10:   w_inc[k] = r_s1_sgn[k] ? (r_s1_r[k] & r_s1_s[k]) : r_s1_r[k];
        default: w_inc[k] = 1'b0;
      endcase
      // The kept value always fits in width_o bits, so this sum cannot wrap.
      w_sum[k] = r_s1_shf[k] + W1'(w_inc[k]);
      w_ofl[k] = w_sum[k][width_o] ^ w_sum[k][width_o-1];
      if (w_ofl[k])
        w_rnd[k*width_o +: width_o] = w_sum[k][width_o] ? {1'b1, {(width_o-1){1'b0}}}
                                                        : {1'b0, {(width_o-1){1'b1}}};
      else
        w_rnd[k*width_o +: width_o] = w_sum[k][width_o-1:0];
    end
  end

  logic [n_lanes*width_o-1:0] r_rnd;
  logic [n_lanes-1:0]         r_ofl;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s2_valid <= 1'b0;
      r_rnd      <= '0;
      r_ofl      <= '0;
    end else if (w_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_rnd <= w_rnd;
        r_ofl <= w_ofl;
      end
    end
  end

  assign o_valid = r_s2_valid;
  assign o_rnd   = r_rnd;
  assign o_ofl   = r_ofl;

  // ---------------- optional overflow counter ----------------
`ifdef SHIFT_RND_OFL_CNT_EN
  logic [15:0] r_ofl_cnt;
  logic        w_xfer;

  assign w_xfer = r_s2_valid & i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_ofl_cnt <= 16'h0000;
    else if (i_cnt_clr)
      r_ofl_cnt <= 16'h0000;
    else if (w_xfer && (|r_ofl) && (r_ofl_cnt != 16'hFFFF))
      r_ofl_cnt <= r_ofl_cnt + 16'h0001;
  end

  assign o_ofl_cnt = r_ofl_cnt;
`else
  logic w_unused_cnt_clr;
  assign w_unused_cnt_clr = i_cnt_clr;
  assign o_ofl_cnt        = 16'h0000;
`endif

endmodule

// File: tb/tb_shift_rnd_pipe.sv
module tb_shift_rnd_pipe;

  localparam int N  = 4;
  localparam int WI = 9;
  localparam int WO = 8;
  localparam int WS = 4;
  localparam int EW = N*WO + N;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              i_rst_n   = 1'b0;
  logic [N*WI-1:0]   i_num     = '0;
  logic [WS-1:0]     i_shift   = '0;
  logic [1:0]        i_mode    = 2'b00;
  logic              i_valid   = 1'b0;
  logic              i_ready   = 1'b1;
  logic              i_cnt_clr = 1'b0;
  logic              o_ready;
  logic [N*WO-1:0]   o_rnd;
  logic [N-1:0]      o_ofl;
  logic              o_valid;
  logic [15:0]       o_ofl_cnt;

  shift_rnd_pipe #(.n_lanes(N), .width_i(WI), .width_o(WO), .width_shift(WS)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_num(i_num), .i_shift(i_shift), .i_mode(i_mode),
    .i_valid(i_valid), .o_ready(o_ready), .o_rnd(o_rnd), .o_ofl(o_ofl), .o_valid(o_valid),
    .i_ready(i_ready), .i_cnt_clr(i_cnt_clr), .o_ofl_cnt(o_ofl_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [EW-1:0] exp_q[$];
  logic [15:0]   exp_cnt = 16'h0000;

  // ---------------- reference model ----------------
  // Arithmetic: floor quotient plus remainder, rounding decided by comparing
  // the remainder with half of the divisor.
  function automatic logic [EW-1:0] model(input logic [N*WI-1:0] num,
                                          input logic [WS-1:0] sh, input logic [1:0] md);
    longint v, q, p, rem, half, r;
    int t;
    logic inc;
    logic [N*WO-1:0] rnd;
    logic [N-1:0] ofl;
    t = int'(sh) + (WI - WO);
    rnd = '0;
    ofl = '0;
    for (int k = 0; k < N; k++) begin
      v    = longint'($signed(num[k*WI +: WI]));
      p    = longint'(1) << t;
      q    = v >>> t;
      rem  = v - q * p;
      half = p / 2;
      case (md)
        2'b00:   inc = (rem > half) || ((rem == half) && (q[0] == 1'b1));
        2'b01:   inc = (v < 0) && (rem != 0);
        2'b10:   inc = (rem > half) || ((rem == half) && (v >= 0));
        default: inc = 1'b0;
      endcase
      r = q + (inc ? 1 : 0);
      if (r > 127) begin
        r = 127;
        ofl[k] = 1'b1;
      end else if (r < -128) begin
        r = -128;
        ofl[k] = 1'b1;
      end
      rnd[k*WO +: WO] = r[WO-1:0];
    end
    return {ofl, rnd};
  endfunction

  // ---------------- scoreboard monitor ----------------
  logic [EW-1:0] mon_e;
  logic [N-1:0]  mon_ofl;

  always @(negedge clk) begin
    if (!i_rst_n) begin
      exp_cnt = 16'h0000;
    end else begin
      mon_ofl = '0;
      if (i_valid && o_ready)
        exp_q.push_back(model(i_num, i_shift, i_mode));
      if (o_valid && i_ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL beat_spurious: got rnd=%h ofl=%b, expected no output beat", o_rnd, o_ofl);
        end else begin
          mon_e   = exp_q.pop_front();
          mon_ofl = mon_e[EW-1 -: N];
          if ({o_ofl, o_rnd} !== mon_e) begin
            n_fail++;
            $display("FAIL beat_data: got ofl=%b rnd=%h, expected ofl=%b rnd=%h",
                     o_ofl, o_rnd, mon_ofl, mon_e[N*WO-1:0]);
          end
        end
      end
`ifdef SHIFT_RND_OFL_CNT_EN
      if (i_cnt_clr)
        exp_cnt = 16'h0000;
      else if (o_valid && i_ready && (|mon_ofl) && (exp_cnt != 16'hFFFF))
        exp_cnt = exp_cnt + 16'h0001;
`endif
    end
  end

  // Global watchdog.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [N*WI-1:0] num, input logic [WS-1:0] sh,
                      input logic [1:0] md, output int waits);
    logic acc;
    i_num = num; i_shift = sh; i_mode = md; i_valid = 1'b1;
    waits = 0;
    acc = 1'b0;
    while (!acc && waits < 50) begin
      @(negedge clk);
      acc = o_ready;
      @(posedge clk);
      #1;
      if (!acc) waits++;
    end
    if (!acc) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: got o_ready=0 for 50 cycles, expected acceptance");
    end
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 100) begin
      @(posedge clk);
      #1;
      c++;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d beats outstanding, expected 0", exp_q.size());
    end
  endtask

  function automatic logic [N*WI-1:0] rnd_num();
    return (N*WI)'({$urandom(), $urandom()});
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    i_rst_n = 1'b0;
    #3;
    n_tests++;
    if ({o_valid, o_ofl, o_rnd, o_ofl_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b ofl=%b rnd=%h cnt=%h, expected all 0",
               o_valid, o_ofl, o_rnd, o_ofl_cnt);
    end
    repeat (2) @(posedge clk);
    #1 i_rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got ready=%b valid=%b, expected ready=1 valid=0", o_ready, o_valid);
    end
  endtask

  typedef struct packed {
    logic [8:0] a0;
    logic [8:0] a1;
    logic [3:0] sh;
    logic [1:0] md;
    logic [7:0] e0;
    logic [7:0] e1;
    logic [1:0] eo;
  } vec_t;

  task automatic test_literals();
    vec_t tbl[12];
    int w;
    tbl[0]  = '{9'd3,   9'd0,   4'd0,  2'b00, 8'd2,  8'h00, 2'b00};
    tbl[1]  = '{9'd3,   9'd0,   4'd0,  2'b01, 8'd1,  8'h00, 2'b00};
    tbl[2]  = '{9'd3,   9'd0,   4'd0,  2'b10, 8'd2,  8'h00, 2'b00};
    tbl[3]  = '{9'd3,   9'd0,   4'd0,  2'b11, 8'd1,  8'h00, 2'b00};
    tbl[4]  = '{9'h1FD, 9'd0,   4'd0,  2'b00, 8'hFE, 8'h00, 2'b00};
    tbl[5]  = '{9'h1FD, 9'd0,   4'd0,  2'b01, 8'hFF, 8'h00, 2'b00};
    tbl[6]  = '{9'h1FD, 9'd0,   4'd0,  2'b10, 8'hFE, 8'h00, 2'b00};
    tbl[7]  = '{9'h1FD, 9'd0,   4'd0,  2'b11, 8'hFE, 8'h00, 2'b00};
    tbl[8]  = '{9'd255, 9'h100, 4'd0,  2'b00, 8'h7F, 8'h80, 2'b01};
    tbl[9]  = '{9'd255, 9'h100, 4'd0,  2'b11, 8'h7F, 8'h80, 2'b00};
    tbl[10] = '{9'h1FF, 9'd0,   4'd15, 2'b00, 8'h00, 8'h00, 2'b00};
    tbl[11] = '{9'h1FF, 9'd0,   4'd15, 2'b11, 8'hFF, 8'h00, 2'b00};
    i_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      send({18'd0, tbl[i].a1, tbl[i].a0}, tbl[i].sh, tbl[i].md, w);
      @(negedge clk);
      n_tests++;
      if (o_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL latency_early[%0d]: got o_valid=%b one cycle after accept, expected 0", i, o_valid);
      end
      @(posedge clk);
      #1;
      @(negedge clk);
      n_tests++;
      if (o_valid !== 1'b1 || o_rnd[7:0] !== tbl[i].e0 || o_rnd[15:8] !== tbl[i].e1 ||
          o_ofl[1:0] !== tbl[i].eo) begin
        n_fail++;
        $display("FAIL literal[%0d]: got valid=%b lane0=%h lane1=%h ofl=%b, expected valid=1 lane0=%h lane1=%h ofl=%b",
                 i, o_valid, o_rnd[7:0], o_rnd[15:8], o_ofl[1:0], tbl[i].e0, tbl[i].e1, tbl[i].eo);
      end
      @(posedge clk);
      #1;
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int w, tot;
    tot = 0;
    i_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(rnd_num(), WS'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), w);
      tot += w;
    end
    n_tests++;
    if (tot != 0) begin
      n_fail++;
      $display("FAIL throughput: got %0d stall cycles, expected 0", tot);
    end
    drain();
  endtask

  task automatic test_stall();
    int w;
    logic [N*WO-1:0] held_rnd;
    logic [N-1:0] held_ofl;
    logic bad;
    i_ready = 1'b0;
    send(rnd_num(), WS'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), w);
    send(rnd_num(), WS'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), w);
    @(negedge clk);
    n_tests++;
    if (o_ready !== 1'b0 || o_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_full: got ready=%b valid=%b, expected ready=0 valid=1", o_ready, o_valid);
    end
    held_rnd = o_rnd;
    held_ofl = o_ofl;
    bad = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      if (o_rnd !== held_rnd || o_ofl !== held_ofl || o_valid !== 1'b1 || o_ready !== 1'b0) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL stall_hold: got rnd=%h ofl=%b valid=%b ready=%b, expected rnd=%h ofl=%b valid=1 ready=0",
               o_rnd, o_ofl, o_valid, o_ready, held_rnd, held_ofl);
    end
    @(posedge clk);
    #1 i_ready = 1'b1;
    for (int i = 0; i < 4; i++)
      send(rnd_num(), WS'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), w);
    drain();
  endtask

  task automatic test_random();
    int w;
    logic done;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++)
          send(rnd_num(), WS'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), w);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 i_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    i_ready = 1'b1;
    drain();
    n_tests++;
    if (o_ofl_cnt !== exp_cnt) begin
      n_fail++;
      $display("FAIL cnt_random: got %h, expected %h", o_ofl_cnt, exp_cnt);
    end
  endtask

  task automatic test_counter();
    int w;
    logic [15:0] lit3;
`ifdef SHIFT_RND_OFL_CNT_EN
    lit3 = 16'd3;
`else
    lit3 = 16'd0;
`endif
    i_ready = 1'b1;
    i_cnt_clr = 1'b1;
    @(posedge clk);
    #1 i_cnt_clr = 1'b0;
    for (int i = 0; i < 3; i++)
      send({18'd0, 9'd0, 9'd255}, 4'd0, 2'b00, w);
    send({18'd0, 9'd0, 9'd3}, 4'd0, 2'b00, w);
    drain();
    n_tests++;
    if (o_ofl_cnt !== lit3 || o_ofl_cnt !== exp_cnt) begin
      n_fail++;
      $display("FAIL cnt_incr: got %h, expected %h", o_ofl_cnt, lit3);
    end
    // Overflow beat leaves on the same edge that the clear is applied.
    i_ready = 1'b0;
    send({18'd0, 9'd0, 9'd255}, 4'd0, 2'b00, w);
    @(posedge clk);
    #1;
    i_ready = 1'b1;
    i_cnt_clr = 1'b1;
    @(posedge clk);
    #1 i_cnt_clr = 1'b0;
    drain();
    n_tests++;
    if (o_ofl_cnt !== 16'd0 || exp_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL cnt_clr_wins: got %h, expected 0000", o_ofl_cnt);
    end
  endtask

  task automatic test_reset_inflight();
    int w;
    logic stale;
    i_ready = 1'b1;
    send(rnd_num(), 4'd0, 2'b00, w);
    send({18'd0, 9'd0, 9'd255}, 4'd0, 2'b00, w);
    #1 i_rst_n = 1'b0;
    #1;
    n_tests++;
    if (o_valid !== 1'b0 || o_ofl_cnt !== 16'd0 || o_ofl !== '0) begin
      n_fail++;
      $display("FAIL reset_async: got valid=%b ofl=%b cnt=%h, expected 0", o_valid, o_ofl, o_ofl_cnt);
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 i_rst_n = 1'b1;
    stale = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (o_valid !== 1'b0) stale = 1'b1;
    end
    n_tests++;
    if (stale) begin
      n_fail++;
      $display("FAIL reset_stale: got o_valid=1 after release, expected 0");
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_literals();
    test_back_to_back();
    test_stall();
    test_counter();
    test_random();
    test_reset_inflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
